// File: rtl/game_sprite_engine.sv
// Single-sprite engine: periodic movement with wrap/bounce/stop edge handling,
// frame-based animation driven by movement steps, and a one-clock-latency
// pixel lookup that reports colour and opacity at the current beam position.

`ifndef GAME_RGB_WIDTH
`define GAME_RGB_WIDTH 4
`endif

module game_sprite_engine #(
    parameter int SPRITE_WIDTH  = 16,
    parameter int SPRITE_HEIGHT = 16,
    parameter int NUM_FRAMES    = 2,
    parameter logic [NUM_FRAMES*SPRITE_WIDTH*SPRITE_HEIGHT*4-1:0] BITMAP = '0,
    parameter int DX_WIDTH      = 4,
    parameter int DY_WIDTH      = 4,
    parameter int EDGE_MODE     = 0,
    parameter int FRAME_DIV     = 8,
    parameter int STROBE_WIDTH  = 20,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    localparam int w_x = $clog2(screen_width),
    localparam int w_y = $clog2(screen_height),
    localparam int FW  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [w_x-1:0]              pixel_x,
    input  logic [w_y-1:0]              pixel_y,
    input  logic                        write_xy,
    input  logic                        write_dxy,
    input  logic [w_x-1:0]              write_x,
    input  logic [w_y-1:0]              write_y,
    input  logic [DX_WIDTH-1:0]         write_dx,
    input  logic [DY_WIDTH-1:0]         write_dy,
    input  logic                        enable_update,
    output logic [w_x-1:0]              sprite_x,
    output logic [w_y-1:0]              sprite_y,
    output logic [FW-1:0]               frame_idx,
    output logic                        hit_edge,
    output logic                        rgb_en,
    output logic [`GAME_RGB_WIDTH-1:0]  rgb
);

    localparam int CW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int RGB_W = `GAME_RGB_WIDTH;
    localparam logic signed [w_x+1:0] XMAX = (w_x+2)'(screen_width - SPRITE_WIDTH);
    localparam logic signed [w_y+1:0] YMAX = (w_y+2)'(screen_height - SPRITE_HEIGHT);

    // Saturating negation: the most negative velocity has no positive twin,
    // so it turns into the largest positive one instead of staying negative.
    function automatic logic signed [DX_WIDTH-1:0] neg_dx(input logic signed [DX_WIDTH-1:0] v);
        if (v == $signed({1'b1, {(DX_WIDTH-1){1'b0}}}))
            return $signed({1'b0, {(DX_WIDTH-1){1'b1}}});
        return -v;
    endfunction

    function automatic logic signed [DY_WIDTH-1:0] neg_dy(input logic signed [DY_WIDTH-1:0] v);
        if (v == $signed({1'b1, {(DY_WIDTH-1){1'b0}}}))
            return $signed({1'b0, {(DY_WIDTH-1){1'b1}}});
        return -v;
    endfunction

    logic [STROBE_WIDTH-1:0]     r_strobe;
    logic [w_x-1:0]              r_x;
    logic [w_y-1:0]              r_y;
    logic signed [DX_WIDTH-1:0]  r_dx;
    logic signed [DY_WIDTH-1:0]  r_dy;
    logic [CW-1:0]               r_step_cnt;
    logic [FW-1:0]               r_frame;
    logic                        r_hit;
    logic                        r_rgb_en;
    logic [RGB_W-1:0]            r_rgb;

    logic                        w_step;
    logic signed [w_x+1:0]       w_nx;
    logic signed [w_y+1:0]       w_ny;
    logic [w_x-1:0]              w_x_nxt;
    logic [w_y-1:0]              w_y_nxt;
    logic signed [DX_WIDTH-1:0]  w_dx_nxt;
    logic signed [DY_WIDTH-1:0]  w_dy_nxt;
    logic                        w_hit_x;
    logic                        w_hit_y;

    logic [w_x:0]                w_x_end;
    logic [w_y:0]                w_y_end;
    logic                        w_inside;
    logic [w_x-1:0]              w_col;
    logic [w_y-1:0]              w_row;
    logic [31:0]                 w_idx;
    logic [3:0]                  w_nib;

    assign w_step = (r_strobe == '0) && enable_update;

    // Candidate positions, sign-extended two bits past the screen range so
    // both underflow (negative) and overflow are visible.
    assign w_nx = $signed({2'b00, r_x}) + $signed({{(w_x+2-DX_WIDTH){r_dx[DX_WIDTH-1]}}, r_dx});
    assign w_ny = $signed({2'b00, r_y}) + $signed({{(w_y+2-DY_WIDTH){r_dy[DY_WIDTH-1]}}, r_dy});

    // X-axis edge handling for the candidate step.
    always_comb begin
        w_x_nxt  = w_nx[w_x-1:0];
        w_dx_nxt = r_dx;
        w_hit_x  = 1'b0;
        if (w_nx[w_x+1]) begin
            w_hit_x = 1'b1;
            case (EDGE_MODE)
                0:       w_x_nxt = XMAX[w_x-1:0];
                1:       begin w_x_nxt = '0; w_dx_nxt = neg_dx(r_dx); end
                default: begin w_x_nxt = '0; w_dx_nxt = '0; end
            endcase
        end else if (w_nx > XMAX) begin
            w_hit_x = 1'b1;
            case (EDGE_MODE)
                0:       w_x_nxt = '0;
                1:       begin w_x_nxt = XMAX[w_x-1:0]; w_dx_nxt = neg_dx(r_dx); end
                default: begin w_x_nxt = XMAX[w_x-1:0]; w_dx_nxt = '0; end
            endcase
        end else begin
            w_hit_x = (w_nx == '0) || (w_nx == XMAX);
        end
    end

    // Y-axis edge handling, same rules as X.
    always_comb begin
        w_y_nxt  = w_ny[w_y-1:0];
        w_dy_nxt = r_dy;
        w_hit_y  = 1'b0;
        if (w_ny[w_y+1]) begin
            w_hit_y = 1'b1;
            case (EDGE_MODE)
                0:       w_y_nxt = YMAX[w_y-1:0];
                1:       begin w_y_nxt = '0; w_dy_nxt = neg_dy(r_dy); end
                default: begin w_y_nxt = '0; w_dy_nxt = '0; end
            endcase
        end else if (w_ny > YMAX) begin
            w_hit_y = 1'b1;
            case (EDGE_MODE)
                0:       w_y_nxt = '0;
                1:       begin w_y_nxt = YMAX[w_y-1:0]; w_dy_nxt = neg_dy(r_dy); end
                default: begin w_y_nxt = YMAX[w_y-1:0]; w_dy_nxt = '0; end
            endcase
        end else begin
            w_hit_y = (w_ny == '0) || (w_ny == YMAX);
        end
    end

    // Movement state: host writes take priority over the step result,
    // while step-driven animation and edge pulses proceed regardless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_strobe   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_step_cnt <= '0;
            r_frame    <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_strobe <= r_strobe + 1'b1;
            r_hit    <= w_step && (w_hit_x || w_hit_y);

            if (write_xy) begin
                r_x <= write_x;
                r_y <= write_y;
            end else if (w_step) begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
            end

            if (write_dxy) begin
                r_dx <= $signed(write_dx);
                r_dy <= $signed(write_dy);
            end else if (w_step) begin
                r_dx <= w_dx_nxt;
                r_dy <= w_dy_nxt;
            end

            if (w_step) begin
                if (r_step_cnt == CW'(FRAME_DIV - 1)) begin
                    r_step_cnt <= '0;
                    r_frame    <= (r_frame == FW'(NUM_FRAMES - 1)) ? '0 : r_frame + FW'(1);
                end else begin
                    r_step_cnt <= r_step_cnt + CW'(1);
                end
            end
        end
    end

    // Bitmap lookup; the index is forced to 0 outside the sprite so the
    // part-select always stays within the bitmap.
    assign w_x_end  = {1'b0, r_x} + (w_x+1)'(SPRITE_WIDTH);
    assign w_y_end  = {1'b0, r_y} + (w_y+1)'(SPRITE_HEIGHT);
    assign w_inside = (pixel_x >= r_x) && ({1'b0, pixel_x} < w_x_end) &&
                      (pixel_y >= r_y) && ({1'b0, pixel_y} < w_y_end);
    assign w_col    = pixel_x - r_x;
    assign w_row    = pixel_y - r_y;
    assign w_idx    = w_inside ? (32'(r_frame) * 32'(SPRITE_WIDTH * SPRITE_HEIGHT) +
                                  32'(w_row) * 32'(SPRITE_WIDTH) + 32'(w_col)) : 32'd0;
    assign w_nib    = BITMAP[{w_idx[29:0], 2'b00} +: 4];

    // Registered display output, one clock behind the beam position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb_en <= 1'b0;
            r_rgb    <= '0;
        end else begin
            r_rgb_en <= w_inside && (w_nib != 4'd0);
            r_rgb    <= (w_inside && (w_nib != 4'd0)) ? w_nib[RGB_W-1:0] : '0;
        end
    end

    assign sprite_x  = r_x;
    assign sprite_y  = r_y;
    assign frame_idx = r_frame;
    assign hit_edge  = r_hit;
    assign rgb_en    = r_rgb_en;
    assign rgb       = r_rgb;

endmodule

// File: tb/tb_game_sprite_engine.sv
// Scoreboard bench for game_sprite_engine: three instances (wrap, bounce,
// stop) share the beam and write buses; expectations are queued with the
// cycle they are due and a monitor pops and compares them on falling edges.

module tb_game_sprite_engine;

    localparam logic [2047:0] BMP = (2048'd5 << 72) | (2048'd9 << 1096) | 2048'd3;
    localparam int F_X = 0, F_Y = 1, F_FR = 2, F_HIT = 3, F_EN = 4, F_RGB = 5;

    typedef struct {
        int    due;
        int    sel;
        int    exp;
        string name;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] pix_x = 10'd600;
    logic [8:0] pix_y = 9'd400;
    logic [2:0] wxy = '0;
    logic [2:0] wdxy = '0;
    logic [9:0] write_x = '0;
    logic [8:0] write_y = '0;
    logic [3:0] write_dx = '0;
    logic [3:0] write_dy = '0;
    logic       en_upd = 1'b0;

    logic [9:0] sx  [3];
    logic [8:0] sy  [3];
    logic       fr  [3];
    logic       hit [3];
    logic       en  [3];
    logic [3:0] rgb [3];

    int   cyc = 0;
    logic [2:0] ph;
    chk_t q[$];
    int   checks = 0;
    int   failures = 0;
    chk_t cur;
    int   act;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the strobe phase: a step happens on the edge where ph == 0.
    always @(posedge clk or negedge rst) begin
        if (!rst) ph <= 3'd0;
        else      ph <= ph + 3'd1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        game_sprite_engine #(
            .SPRITE_WIDTH(16), .SPRITE_HEIGHT(16), .NUM_FRAMES(2), .BITMAP(BMP),
            .DX_WIDTH(4), .DY_WIDTH(4), .EDGE_MODE(g), .FRAME_DIV(2),
            .STROBE_WIDTH(3), .screen_width(640), .screen_height(480)
        ) u_dut (
            .clk(clk), .rst(rst), .pixel_x(pix_x), .pixel_y(pix_y),
            .write_xy(wxy[g]), .write_dxy(wdxy[g]),
            .write_x(write_x), .write_y(write_y),
            .write_dx(write_dx), .write_dy(write_dy),
            .enable_update(en_upd),
            .sprite_x(sx[g]), .sprite_y(sy[g]), .frame_idx(fr[g]),
            .hit_edge(hit[g]), .rgb_en(en[g]), .rgb(rgb[g])
        );
    end

    function automatic int actual(int sel);
        int i;
        i = sel / 8;
        case (sel % 8)
            F_X:     return int'(sx[i]);
            F_Y:     return int'(sy[i]);
            F_FR:    return int'(fr[i]);
            F_HIT:   return int'(hit[i]);
            F_EN:    return int'(en[i]);
            default: return int'(rgb[i]);
        endcase
    endfunction

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            cur = q.pop_front();
            act = actual(cur.sel);
            checks++;
            if (act != cur.exp) begin
                failures++;
                $display("FAIL %s: got %0d, expected %0d", cur.name, act, cur.exp);
            end
        end
    end

    task automatic push(string nm, int inst, int f, int exp, int lag);
        chk_t c;
        c.due  = cyc + lag;
        c.sel  = inst * 8 + f;
        c.exp  = exp;
        c.name = nm;
        q.push_back(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wr(int inst, int x, int y, int dx, int dy);
        @(negedge clk);
        write_x    = x[9:0];
        write_y    = y[8:0];
        write_dx   = dx[3:0];
        write_dy   = dy[3:0];
        wxy[inst]  = 1'b1;
        wdxy[inst] = 1'b1;
        @(negedge clk);
        wxy  = '0;
        wdxy = '0;
    endtask

    // Stop just before a strobe edge and allow that edge to step.
    task automatic arm();
        @(negedge clk);
        while (ph != 3'd0) @(negedge clk);
        en_upd = 1'b1;
    endtask

    task automatic fire();
        @(negedge clk);
        en_upd = 1'b0;
        wxy    = '0;
        wdxy   = '0;
    endtask

    task automatic beam(int x, int y, int exp_en, int exp_rgb, string nm);
        @(negedge clk);
        pix_x = x[9:0];
        pix_y = y[8:0];
        push({nm, "_en"}, 0, F_EN, exp_en, 1);
        push({nm, "_rgb"}, 0, F_RGB, exp_rgb, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held: every output at zero.
        repeat (3) @(negedge clk);
        checks++;
        if (sx[1] !== 10'd0) begin
            failures++;
            $display("FAIL rst_x1: got %0d, expected 0", sx[1]);
        end
        checks++;
        if (sy[1] !== 9'd0) begin
            failures++;
            $display("FAIL rst_y1: got %0d, expected 0", sy[1]);
        end
        checks++;
        if (hit[1] !== 1'b0) begin
            failures++;
            $display("FAIL rst_hit1: got %0d, expected 0", hit[1]);
        end
        checks++;
        if (sx[2] !== 10'd0) begin
            failures++;
            $display("FAIL rst_x2: got %0d, expected 0", sx[2]);
        end
        checks++;
        if (sy[2] !== 9'd0) begin
            failures++;
            $display("FAIL rst_y2: got %0d, expected 0", sy[2]);
        end
        checks++;
        if (en[2] !== 1'b0) begin
            failures++;
            $display("FAIL rst_en2: got %0d, expected 0", en[2]);
        end
        push("rst_x", 0, F_X, 0, 1);
        push("rst_y", 0, F_Y, 0, 1);
        push("rst_frame", 0, F_FR, 0, 1);
        push("rst_hit", 0, F_HIT, 0, 1);
        push("rst_rgb_en", 0, F_EN, 0, 1);
        push("rst_rgb", 0, F_RGB, 0, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // After release, zero velocity keeps the sprite at the origin bound.
        arm();
        push("rel_x", 0, F_X, 0, 1);
        push("rel_y", 0, F_Y, 0, 1);
        push("rel_hit", 0, F_HIT, 1, 1);
        fire();
        push("rel_hit_drop", 0, F_HIT, 0, 1);

        // Wrap mode.
        do_reset();
        wr(0, 622, 100, 3, 0);
        arm();
        push("wrap_hi_x", 0, F_X, 0, 1);
        push("wrap_hi_y", 0, F_Y, 100, 1);
        push("wrap_hi_hit", 0, F_HIT, 1, 1);
        fire();
        push("wrap_hit_pulse", 0, F_HIT, 0, 1);
        wr(0, 1, 100, -3, 0);
        arm();
        push("wrap_lo_x", 0, F_X, 624, 1);
        push("wrap_lo_hit", 0, F_HIT, 1, 1);
        fire();

        // Bounce mode.
        do_reset();
        wr(1, 2, 100, -4, 0);
        arm();
        push("bnc_x0", 1, F_X, 0, 1);
        push("bnc_hit0", 1, F_HIT, 1, 1);
        fire();
        arm();
        push("bnc_x4", 1, F_X, 4, 1);
        push("bnc_hit_none", 1, F_HIT, 0, 1);
        push("bnc_frame1", 1, F_FR, 1, 1);
        fire();
        wr(1, 3, 100, -8, 0);
        arm();
        push("bnc_min_x0", 1, F_X, 0, 1);
        fire();
        arm();
        push("bnc_min_x7", 1, F_X, 7, 1);
        push("bnc_frame0", 1, F_FR, 0, 1);
        fire();

        // Stop mode on the Y axis.
        do_reset();
        wr(2, 100, 462, 0, 2);
        arm();
        push("stop_land_y", 2, F_Y, 464, 1);
        push("stop_land_hit", 2, F_HIT, 1, 1);
        fire();
        arm();
        push("stop_clamp_y", 2, F_Y, 464, 1);
        push("stop_clamp_hit", 2, F_HIT, 1, 1);
        fire();
        arm();
        push("stop_dy0_y", 2, F_Y, 464, 1);
        fire();

        // Host write on the strobe cycle vs. step and animation.
        do_reset();
        wr(0, 300, 200, 5, 5);
        arm();
        push("ws_s1_x", 0, F_X, 305, 1);
        push("ws_s1_frame", 0, F_FR, 0, 1);
        fire();
        arm();
        write_x = 10'd100;
        write_y = 9'd50;
        wxy[0]  = 1'b1;
        push("ws_s2_x", 0, F_X, 100, 1);
        push("ws_s2_y", 0, F_Y, 50, 1);
        push("ws_s2_frame", 0, F_FR, 1, 1);
        fire();
        arm();
        push("ws_s3_x", 0, F_X, 105, 1);
        push("ws_s3_y", 0, F_Y, 55, 1);
        fire();
        arm();
        push("ws_s4_x", 0, F_X, 110, 1);
        push("ws_s4_frame", 0, F_FR, 0, 1);
        fire();

        // Display lookup.
        do_reset();
        wr(0, 10, 20, 0, 0);
        beam(12, 21, 1, 5, "dsp_hit5");
        beam(13, 21, 0, 0, "dsp_zero");
        beam(26, 21, 0, 0, "dsp_right");
        beam(10, 20, 1, 3, "dsp_corner");
        beam(25, 35, 0, 0, "dsp_last");
        beam(9, 20, 0, 0, "dsp_left");
        beam(10, 19, 0, 0, "dsp_above");
        arm();
        fire();
        arm();
        push("dsp_frame1", 0, F_FR, 1, 1);
        push("dsp_hold_x", 0, F_X, 10, 1);
        fire();
        beam(12, 21, 1, 9, "dsp_f1");

        for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
        while (q.size() > 0) begin
            cur = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: got no sample, expected %0d", cur.name, cur.exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
